// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: PFU->ID->EX handshake, 32-entry destination scoreboard, RAW/WAW stall, post-redirect drain.
// Optional macro MERLIN_ID_WB_BYPASS_EN: same-cycle write-back releases RAW hazards (regfile forwards data).
module id_issue_ctrl #(
  parameter int P_XLEN = 32
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  input  logic        pfu_dav_i,
  input  logic        pfu_sofr_i,
  input  logic        pfu_ferr_i,
  output logic        pfu_pull_o,
  input  logic        dec_ins_err_i,
  input  logic        dec_rs1_rd_i,
  input  logic        dec_rs2_rd_i,
  input  logic [4:0]  dec_rs1_addr_i,
  input  logic [4:0]  dec_rs2_addr_i,
  input  logic        dec_regd_wr_i,
  input  logic [4:0]  dec_regd_addr_i,
  output logic        id_load_o,
  output logic        ids_dav_o,
  output logic        ids_exc_o,
  input  logic        ids_ack_i,
  input  logic        ex_flush_i,
  input  logic        wb_regd_wr_i,
  input  logic [4:0]  wb_regd_addr_i,
  output logic        hazard_stall_o,
  output logic [31:0] sb_pending_o
);

  if (P_XLEN < 32) begin : g_narrow_xlen
  end

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t      state, state_nxt;
  logic        ids_dav, ids_exc, held_wr;
  logic [4:0]  held_rd;
  logic [31:0] sb, sb_nxt, sb_rs;

  logic ins_err, rs1_use, rs2_use, rd_use;
  logic haz_rs1, haz_rs2, haz_rd, hazard;
  logic run, pull, load;

  // Faulted instructions never touch the register file, so their operands are ignored.
  assign ins_err = pfu_ferr_i | dec_ins_err_i;
  assign rs1_use = dec_rs1_rd_i & ~ins_err;
  assign rs2_use = dec_rs2_rd_i & ~ins_err;
  assign rd_use  = dec_regd_wr_i & ~ins_err;

  always_comb begin
    sb_rs = sb;
`ifdef MERLIN_ID_WB_BYPASS_EN
    if (wb_regd_wr_i) sb_rs[wb_regd_addr_i] = 1'b0;
`endif
  end

  // The held (not yet acked) instruction is in flight but not in the scoreboard yet.
  assign haz_rs1 = rs1_use && (dec_rs1_addr_i != 5'd0) &&
                   (sb_rs[dec_rs1_addr_i] || (ids_dav && held_wr && held_rd == dec_rs1_addr_i));
  assign haz_rs2 = rs2_use && (dec_rs2_addr_i != 5'd0) &&
                   (sb_rs[dec_rs2_addr_i] || (ids_dav && held_wr && held_rd == dec_rs2_addr_i));
  assign haz_rd  = rd_use && (dec_regd_addr_i != 5'd0) &&
                   (sb[dec_regd_addr_i] || (ids_dav && held_wr && held_rd == dec_regd_addr_i));
  assign hazard  = haz_rs1 | haz_rs2 | haz_rd;

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    pull      = 1'b0;
    load      = 1'b0;
    case (state)
      ST_RUN: begin
        run  = 1'b1;
        pull = clk_en_i & pfu_dav_i & ~hazard & (~ids_dav | ids_ack_i) & ~ex_flush_i;
        load = pull;
        if (ex_flush_i) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Stale fetches are pulled and dropped; the sofr fetch waits for RUN.
        pull = clk_en_i & pfu_dav_i & ~pfu_sofr_i;
        if (!ex_flush_i && pfu_dav_i && pfu_sofr_i) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    sb_nxt = sb;
    if (wb_regd_wr_i && wb_regd_addr_i != 5'd0) sb_nxt[wb_regd_addr_i] = 1'b0;
    if (ids_ack_i && ids_dav && held_wr && held_rd != 5'd0) sb_nxt[held_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      state   <= ST_RUN;
      ids_dav <= 1'b0;
      ids_exc <= 1'b0;
      held_wr <= 1'b0;
      held_rd <= 5'd0;
      sb      <= 32'd0;
    end else if (clk_en_i) begin
      state <= state_nxt;
      sb    <= sb_nxt;
      if (ex_flush_i) begin
        ids_dav <= 1'b0;
      end else if (load) begin
        ids_dav <= 1'b1;
        ids_exc <= ins_err;
        held_wr <= rd_use;
        held_rd <= ins_err ? 5'd0 : dec_regd_addr_i;
      end else if (ids_ack_i) begin
        ids_dav <= 1'b0;
      end
    end
  end

  assign pfu_pull_o     = pull;
  assign id_load_o      = load;
  assign ids_dav_o      = ids_dav;
  assign ids_exc_o      = ids_exc;
  assign hazard_stall_o = pfu_dav_i & run & hazard;
  assign sb_pending_o   = sb;

endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Issue controller for the instruction-decode stage. It sits between the prefetch unit (PFU) and the EX stage, and does four things:
- sequences the PFU→ID→EX valid/ack handshake;
- tracks in-flight destination registers in a 32-entry scoreboard;
- stalls decode on RAW/WAW hazards;
- after an EX redirect, discards stale fetches until the new stream begins.

It drives the ID register-stage load enable and the `ids_dav_o` handshake.

## Interface
Parameters:
- `P_XLEN`, 32, datapath width. Informational only; the block carries no data.

Ports:
- `clk_i` in 1: clock, single domain.
- `resetb_i` in 1: reset, synchronous, active-low.
- `clk_en_i` in 1: global clock enable. When low, all state holds and `pfu_pull_o` = 0.
- `pfu_dav_i` in 1: fetch available.
- `pfu_sofr_i` in 1: first fetch since vectoring.
- `pfu_ferr_i` in 1: fetch error on this instruction.
- `pfu_pull_o` out 1: accept the current fetch (combinational).
- `dec_ins_err_i` in 1: decoder flags an undefined instruction.
- `dec_rs1_rd_i`, `dec_rs2_rd_i` in 1 each: source operand is used.
- `dec_rs1_addr_i`, `dec_rs2_addr_i` in 5 each: source register addresses.
- `dec_regd_wr_i` in 1: instruction writes a destination register.
- `dec_regd_addr_i` in 5: destination register address.
- `id_load_o` out 1: load enable for the ID register stage; equals `pfu_pull_o` in RUN when not discarding.
- `ids_dav_o` out 1: ID stage holds a valid instruction (registered).
- `ids_exc_o` out 1: held instruction carries a fetch or decode error (registered).
- `ids_ack_i` in 1: EX accepts the held instruction.
- `ex_flush_i` in 1: EX redirect. Squashes the held instruction and enters DRAIN.
- `wb_regd_wr_i` in 1: write-back pulse.
- `wb_regd_addr_i` in 5: write-back register address.
- `hazard_stall_o` out 1: decode is blocked by the scoreboard (combinational).
- `sb_pending_o` out 32: scoreboard contents, one bit per register; bit 0 is always 0.

## Operation
**FSM states and transitions**
- States: RUN and DRAIN. Reset state is RUN.
- RUN → DRAIN when `ex_flush_i` = 1.
- DRAIN → RUN when `pfu_dav_i` = 1 and `pfu_sofr_i` = 1.
- `ex_flush_i` asserted while in DRAIN keeps the FSM in DRAIN.

**DRAIN behaviour**
- `pfu_pull_o` = `pfu_dav_i` & ~`pfu_sofr_i`: stale fetches are pulled and discarded.
- `id_load_o` = 0.
- The sofr fetch that ends DRAIN is not pulled in that cycle; it is evaluated as a normal RUN fetch in the next cycle.

**Hazard detection**
- Hazard is set for rsN when all of the following hold:
  - `dec_rsN_rd_i` = 1;
  - rsN address ≠ 0;
  - `sb_pending_o[rsN]` = 1, or (`ids_dav_o` = 1 and held_rd_wr = 1 and held_rd = rsN).
- Hazard is also set for rd when all of the following hold:
  - `dec_regd_wr_i` = 1;
  - rd ≠ 0;
  - rd is pending by the same scoreboard/held-instruction test (WAW).
- If `pfu_ferr_i` = 1 or `dec_ins_err_i` = 1, all register uses and writes are treated as 0: no hazard, no scoreboard set.
- `hazard_stall_o` = `pfu_dav_i` & RUN & any hazard.

**Issue (RUN)**
- `pfu_pull_o` = `clk_en_i` & `pfu_dav_i` & ~hazard & (~`ids_dav_o` | `ids_ack_i`) & ~`ex_flush_i`.
- On pull, the controller registers:
  - `ids_dav_o` ← 1;
  - `ids_exc_o` ← `pfu_ferr_i` | `dec_ins_err_i`;
  - held_rd_wr and held_rd from the (error-masked) decoder outputs.

**Handshake**
- `ids_dav_o` is cleared on `ids_ack_i` without a simultaneous pull.
- `ids_dav_o` is cleared on `ex_flush_i`; flush has priority over pull and ack.
- While `ids_dav_o` = 1 and `ids_ack_i` = 0, all held fields are stable.

**Scoreboard**
- Set: `ids_ack_i` & `ids_dav_o` & held_rd_wr & held_rd ≠ 0 sets the held_rd bit.
- Clear: `wb_regd_wr_i` & `wb_regd_addr_i` ≠ 0 clears that bit.
- Set and clear of the same bit in one cycle: set wins.
- Flush does not clear the scoreboard. EX guarantees exactly one write-back pulse per acked instruction with rd ≠ 0.
- Write-back to a register that is not pending is a no-op.

## Timing
- Reset values: FSM = RUN; `ids_dav_o` = 0; `ids_exc_o` = 0; held_rd_wr = 0; held_rd = 0; scoreboard all 0. The combinational outputs therefore evaluate to 0 except through the live `pfu_dav_i` path.
- Reset asserted mid-operation discards the held instruction and all pending bits within one edge.
- Issue latency: pull at edge N → `ids_dav_o` = 1 after edge N.
- Throughput is 1 instruction/cycle when there is no hazard and `ids_ack_i` is continuous.
- RAW stall release:
  - Without bypass: write-back at edge N clears the bit; the dependent instruction pulls at edge N+1.
  - With bypass (see Configuration): the dependent instruction pulls at edge N.
- Flush at edge N: `ids_dav_o` = 0 after N, and the first pull is no earlier than edge N+1.

## Configuration
- `MERLIN_ID_WB_BYPASS_EN`
  - Defined: a source operand whose pending bit is being cleared by `wb_regd_wr_i` in the same cycle does not raise a hazard. The regfile forwards write data to the read port. WAW checks are unaffected.
  - Undefined: the pending bit must be clear at the start of the cycle, which costs one extra stall cycle per RAW hazard.

## Test plan
- **RAW stall:** issue `addi x5` (ack), then `add x6,x5,x1` → `hazard_stall_o` = 1 until `wb_regd_wr_i` for x5; pull one cycle later (same cycle with bypass).
- **Back-pressure:** hold `ids_ack_i` = 0 for 3 cycles with `pfu_dav_i` = 1 → `pfu_pull_o` = 0 and held fields stable; ack → pull in the same cycle, `ids_dav_o` stays 1.
- **x0 writes:** `addi x0` then a reader of x0 → no stall, `sb_pending_o` stays 0.
- **Flush/drain:** `ex_flush_i` with 2 stale fetches, then a sofr fetch → 2 discarded pulls with `id_load_o` = 0, `ids_dav_o` = 0; the sofr fetch issues after returning to RUN.
- **Errors:** `pfu_ferr_i` = 1 on an instruction whose rs1 is pending → no stall, `ids_exc_o` = 1, no scoreboard set on ack.
- **Reset:** sync reset while x3/x7 are pending and `ids_dav_o` = 1 → after one edge all pending bits are 0 and `ids_dav_o` = 0.
